// File: rtl/id_ex_pkg.sv
// Shared constants and the decoded-control bundle for the ID/EX ALU issue stage.
package id_ex_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned WORD_W   = 32;

  // Primary opcodes, instr[31:26]
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  // R-type funct codes, instr[5:0]
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;
  localparam logic [OP_W-1:0] FN_SLL = 6'h00;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_STADDR = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_BUBBLE = 4'hF;

  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_W-1:0]    shamt;
    logic [WORD_W-1:0]   imm;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic                alusrc;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                branch;
  } ex_ctrl_t;

  // Empty EX slot: everything zero except the BUBBLE ALU code
  function automatic ex_ctrl_t bubble_ctrl();
    ex_ctrl_t b;
    b        = '0;
    b.alu_op = ALU_BUBBLE;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_decode.sv
// Combinational MIPS instruction decode into the EX control bundle.
// SLL_SHIFT_EN enables funct 0x00 as SLL; otherwise only the all-zero-shamt/rd NOP form is legal.
module id_ex_decode
  import id_ex_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  output ex_ctrl_t          ctrl_c,
  output logic              illegal_c
);

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            bad;
  logic            nop;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctrl_c   = bubble_ctrl();
    bad      = 1'b0;
    nop      = 1'b0;

    ctrl_c.valid = 1'b1;
    ctrl_c.rs    = instr[25:21];
    ctrl_c.rt    = instr[20:16];
    ctrl_c.imm   = {{16{instr[15]}}, instr[15:0]};
`ifdef SLL_SHIFT_EN
    ctrl_c.shamt = instr[10:6];
`else
    ctrl_c.shamt = '0;
`endif

    // sw and beq have no write target, so rd stays 0
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_c.rd       = instr[15:11];
        ctrl_c.regwrite = 1'b1;
        unique case (funct)
          FN_ADD: ctrl_c.alu_op = ALU_ADD;
          FN_SUB: ctrl_c.alu_op = ALU_SUB;
          FN_AND: ctrl_c.alu_op = ALU_AND;
          FN_OR:  ctrl_c.alu_op = ALU_OR;
          FN_SLT: ctrl_c.alu_op = ALU_SLT;
          FN_SLL: begin
`ifdef SLL_SHIFT_EN
            ctrl_c.alu_op = ALU_SLL;
`else
            if (instr[10:6] == '0 && instr[15:11] == '0) nop = 1'b1;
            else                                          bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_c.alu_op   = ALU_ADD;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memread  = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.rd       = instr[20:16];
      end
      OP_SW: begin
        ctrl_c.alu_op   = ALU_STADDR;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.alu_op = ALU_SUB;
        ctrl_c.branch = 1'b1;
      end
      OP_ADDI: begin
        ctrl_c.alu_op   = ALU_ADD;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.rd       = instr[20:16];
      end
      default: bad = 1'b1;
    endcase

    // Writes to $0 are discarded architecturally
    if (ctrl_c.rd == '0) ctrl_c.regwrite = 1'b0;

    if (bad || nop) ctrl_c = bubble_ctrl();
    illegal_c = bad;
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// Registered ID/EX issue stage: decode, stall/flush priority and saturating illegal counter.
// Optional SLL_SHIFT_EN macro enables SLL issue (see id_ex_decode).
module id_ex_alu_issue
  import id_ex_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   instr,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [REG_W-1:0]    ex_shamt,
  output logic [WORD_W-1:0]   ex_imm,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic                ex_alusrc,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_branch,
  output logic                illegal,
  output logic [CNT_W-1:0]    illegal_count
);

  ex_ctrl_t dec_ctrl;
  logic     dec_illegal;
  ex_ctrl_t ex_q;

  id_ex_decode u_decode (
    .instr     (instr),
    .ctrl_c    (dec_ctrl),
    .illegal_c (dec_illegal)
  );

  // Priority: reset, flush, stall (hold), no input, load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q          <= bubble_ctrl();
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      ex_q    <= bubble_ctrl();
      illegal <= 1'b0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else if (!in_valid) begin
      ex_q    <= bubble_ctrl();
      illegal <= 1'b0;
    end else begin
      ex_q    <= dec_ctrl;
      illegal <= dec_illegal;
      if (dec_illegal && (illegal_count != {CNT_W{1'b1}}))
        illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alu_op   = ex_q.alu_op;
  assign ex_shamt    = ex_q.shamt;
  assign ex_imm      = ex_q.imm;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_branch   = ex_q.branch;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed literal checks plus randomized traffic against a behavioural model.
module tb_id_ex_alu_issue;

  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, flush;
  logic [31:0] instr;
  logic        ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_branch, illegal;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm;
  logic [CNT_W-1:0] illegal_count;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .illegal(illegal), .illegal_count(illegal_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected EX contents
  logic [31:0] m_valid, m_op, m_shamt, m_imm, m_rs, m_rt, m_rd;
  logic [31:0] m_alusrc, m_regwrite, m_memread, m_memwrite, m_branch, m_ill;
  int          m_cnt;

  task automatic model_bubble();
    m_valid = 0; m_op = 32'hF; m_shamt = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_alusrc = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_branch = 0;
  endtask

  // Instruction semantics from the opcode/funct table
  task automatic model_load(input logic [31:0] w);
    int op, fn, code, rd;
    bit legal, nop, wr, src, mr, mw, br;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    legal = 0; nop = 0; code = 15; rd = 0; wr = 0; src = 0; mr = 0; mw = 0; br = 0;
    if (op == 'h00) begin
      rd = int'(w[15:11]); wr = 1;
      legal = 1;
      if      (fn == 'h20) code = 2;
      else if (fn == 'h22) code = 6;
      else if (fn == 'h24) code = 0;
      else if (fn == 'h25) code = 1;
      else if (fn == 'h2A) code = 7;
      else if (fn == 'h00) begin
`ifdef SLL_SHIFT_EN
        code = 8;
`else
        legal = 0;
        nop = (w[10:6] == 0) && (w[15:11] == 0);
`endif
      end else legal = 0;
    end
    else if (op == 'h23) begin legal = 1; code = 2; src = 1; mr = 1; wr = 1; rd = int'(w[20:16]); end
    else if (op == 'h2B) begin legal = 1; code = 4; src = 1; mw = 1; end
    else if (op == 'h04) begin legal = 1; code = 6; br = 1; end
    else if (op == 'h08) begin legal = 1; code = 2; src = 1; wr = 1; rd = int'(w[20:16]); end

    if (!legal) begin
      model_bubble();
      m_ill = nop ? 0 : 1;
      if (!nop && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_ill = 0;
      m_valid = 1; m_op = code; m_rd = rd;
      m_rs = {27'd0, w[25:21]}; m_rt = {27'd0, w[20:16]};
      m_imm = {{16{w[15]}}, w[15:0]};
`ifdef SLL_SHIFT_EN
      m_shamt = {27'd0, w[10:6]};
`else
      m_shamt = 0;
`endif
      m_alusrc = src; m_memread = mr; m_memwrite = mw; m_branch = br;
      m_regwrite = (wr && rd != 0) ? 1 : 0;
    end
  endtask

  // Model step at each edge, then compare every output shortly after
  always @(posedge clk) begin
    if (!rst_n)        begin model_bubble(); m_ill = 0; m_cnt = 0; end
    else if (flush)    begin model_bubble(); m_ill = 0; end
    else if (stall)    m_ill = 0;
    else if (!in_valid) begin model_bubble(); m_ill = 0; end
    else               model_load(instr);
    #1;
    cmp("valid",    {31'd0, ex_valid},    m_valid);
    cmp("alu_op",   {28'd0, ex_alu_op},   m_op);
    cmp("shamt",    {27'd0, ex_shamt},    m_shamt);
    cmp("imm",      ex_imm,               m_imm);
    cmp("rs",       {27'd0, ex_rs},       m_rs);
    cmp("rt",       {27'd0, ex_rt},       m_rt);
    cmp("rd",       {27'd0, ex_rd},       m_rd);
    cmp("alusrc",   {31'd0, ex_alusrc},   m_alusrc);
    cmp("regwrite", {31'd0, ex_regwrite}, m_regwrite);
    cmp("memread",  {31'd0, ex_memread},  m_memread);
    cmp("memwrite", {31'd0, ex_memwrite}, m_memwrite);
    cmp("branch",   {31'd0, ex_branch},   m_branch);
    cmp("illegal",  {31'd0, illegal},     m_ill);
    cmp("count",    {24'd0, illegal_count}, 32'(m_cnt));
  end

  // Apply inputs at a falling edge and return at the next falling edge
  task automatic drive(input logic v, input logic [31:0] w, input logic st, input logic fl);
    in_valid = v; instr = w; stall = st; flush = fl;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: w[5:0] = 6'h20;
          1: w[5:0] = 6'h22;
          2: w[5:0] = 6'h24;
          3: w[5:0] = 6'h25;
          4: w[5:0] = 6'h2A;
          default: w[5:0] = 6'h00;
        endcase
      end
      1: w[31:26] = 6'h23;
      2: w[31:26] = 6'h2B;
      3: w[31:26] = 6'h04;
      4: w[31:26] = 6'h08;
      5: w = 32'd0;
      6: begin
        w[31:26] = 6'h00; w[5:0] = 6'h00;
        if ($urandom_range(0, 1) == 1) w[10:6]  = 5'd0;
        if ($urandom_range(0, 1) == 1) w[15:11] = 5'd0;
      end
      8: w[31:26] = 6'h00;
      9: begin w[31:26] = 6'h00; w[15:11] = 5'd0; w[5:0] = 6'h20; end
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C250008;
  localparam logic [31:0] I_SW   = 32'hAC250004;
  localparam logic [31:0] I_BEQ  = 32'h10220005;
  localparam logic [31:0] I_SLT  = 32'h0022182A;
  localparam logic [31:0] I_SLL  = 32'h000220C0;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    drive(0, 0, 1, 0);
    cmp("lit_rst_valid", {31'd0, ex_valid}, 0);
    cmp("lit_rst_op", {28'd0, ex_alu_op}, 32'hF);
    cmp("lit_rst_cnt", {24'd0, illegal_count}, 0);
    rst_n = 1'b1;

    drive(1, I_ADD, 0, 0);
    cmp("lit_add_op", {28'd0, ex_alu_op}, 2);
    cmp("lit_add_rd", {27'd0, ex_rd}, 3);
    cmp("lit_add_wr", {31'd0, ex_regwrite}, 1);
    cmp("lit_add_valid", {31'd0, ex_valid}, 1);

    drive(1, I_LW, 0, 0);
    cmp("lit_lw_op", {28'd0, ex_alu_op}, 2);
    cmp("lit_lw_src", {31'd0, ex_alusrc}, 1);
    cmp("lit_lw_mr", {31'd0, ex_memread}, 1);
    cmp("lit_lw_imm", ex_imm, 8);
    cmp("lit_lw_rd", {27'd0, ex_rd}, 5);
    drive(1, I_SW, 0, 0);
    cmp("lit_sw_op", {28'd0, ex_alu_op}, 4);
    cmp("lit_sw_mw", {31'd0, ex_memwrite}, 1);
    cmp("lit_sw_wr", {31'd0, ex_regwrite}, 0);
    cmp("lit_sw_imm", ex_imm, 4);

    drive(1, I_BEQ, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, (i == 1) ? I_SLT : I_ADD, 1, 0);
      cmp("lit_stall_op", {28'd0, ex_alu_op}, 6);
      cmp("lit_stall_br", {31'd0, ex_branch}, 1);
    end
    drive(1, I_ADD, 0, 0);
    cmp("lit_after_stall_op", {28'd0, ex_alu_op}, 2);

    drive(1, I_SLT, 1, 1);
    cmp("lit_sf_valid", {31'd0, ex_valid}, 0);
    cmp("lit_sf_op", {28'd0, ex_alu_op}, 32'hF);

    drive(1, I_SLL, 0, 0);
`ifdef SLL_SHIFT_EN
    cmp("lit_sll_op", {28'd0, ex_alu_op}, 8);
    cmp("lit_sll_shamt", {27'd0, ex_shamt}, 3);
`else
    cmp("lit_sll_ill", {31'd0, illegal}, 1);
    cmp("lit_sll_valid", {31'd0, ex_valid}, 0);
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1, I_BAD, 0, 0);
      cmp("lit_ill_high", {31'd0, illegal}, 1);
    end
    cmp("lit_ill_sat", {24'd0, illegal_count}, 255);
    drive(0, 0, 0, 0);
    cmp("lit_ill_drop", {31'd0, illegal}, 0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 7) != 0), rand_instr(),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

- Registered ID/EX issue stage that turns a fetched MIPS instruction into the 4-bit ALU operation code, shift amount and EX/MEM control bits the execute-stage ALU consumes.
- Sits between the IF/ID register and the ALU; it is the producer side of the ALU opcode interface.
- Supports stall (hold), flush (bubble) and illegal-instruction detection, with a saturating illegal counter.

## Interface
Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  IF/ID holds a valid instruction
- instr  in  32  instruction word from IF/ID
- stall  in  1  hold every EX output register
- flush  in  1  replace the next EX contents with a bubble
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_op  out  4  ALU operation code
- ex_shamt  out  5  shift amount, instr[10:6]
- ex_imm  out  32  sign-extended instr[15:0]
- ex_rs, ex_rt, ex_rd  out  5 each  register specifiers; ex_rd is the write target
- ex_alusrc  out  1  1 = ALU b operand is ex_imm
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  EX/MEM controls
- illegal  out  1  one-cycle pulse: undecodable instruction dropped
- illegal_count  out  CNT_W  saturating count of illegal instructions

## Operation
ALU code map:
- AND = 0, OR = 1, ADD = 2, STORE-ADDR = 4, SUB/BEQ = 6, SLT = 7, SLL = 8, BUBBLE = 4'hF.

Decode by instr[31:26]:
- 0x00 R-type, by funct:
  - 0x20 → ADD; 0x22 → SUB; 0x24 → AND; 0x25 → OR; 0x2A → SLT; 0x00 → SLL.
  - rd = instr[15:11], regwrite = 1, alusrc = 0.
- 0x23 lw: ADD, alusrc, memread, regwrite, rd = rt.
- 0x2B sw: STORE-ADDR, alusrc, memwrite.
- 0x04 beq: SUB/BEQ, branch, alusrc = 0.
- 0x08 addi: ADD, alusrc, regwrite, rd = rt.
- Any other opcode or funct is illegal: a bubble is loaded, illegal pulses and the counter increments.
- ex_regwrite is forced to 0 whenever the write target is register 0.

Bubble contents:
- ex_valid = 0, ex_alu_op = 4'hF, all control bits 0.
- ex_rs/rt/rd and ex_imm = 0.

Update priority each clock:
1. rst_n = 0 → bubble, illegal = 0, illegal_count = 0.
2. flush → bubble, regardless of stall. An illegal instruction is not counted on a flush cycle.
3. stall → all EX outputs hold; illegal = 0; the counter does not count.
4. in_valid = 0 → bubble.
5. Otherwise load the decoded instruction.

Counter: increments on each counted illegal instruction and saturates at 2^CNT_W−1 (no wrap).

## Timing
- Latency: 1 clock; instr at edge N appears on ex_* after edge N.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values: ex_valid 0, ex_alu_op 4'hF, every other output 0.
- stall and flush in the same cycle → flush wins.
- A stall lasting k cycles holds the outputs unchanged for k cycles. The next non-stalled edge loads the instr present at that edge.
- illegal is high only for the cycle after the capturing edge. Back-to-back illegal instructions keep it high continuously.
- rst_n asserted while stall is active still clears every register.

## Configuration
- SLL_SHIFT_EN defined:
  - funct 0x00 decodes to SLL (code 8) with ex_shamt = instr[10:6].
  - The all-zero NOP issues as SLL with rd = 0, so regwrite = 0.
- SLL_SHIFT_EN undefined:
  - funct 0x00 with shamt = 0 and rd = 0 is a legal NOP and loads a bubble without counting.
  - Any other funct 0x00 word is illegal.
  - ex_shamt is tied to 0.

## Structure
- Shared package id_ex_pkg:
  - opcode constants (R-type, lw, sw, beq, addi);
  - funct constants;
  - ALU code constants, including BUBBLE;
  - a typedef for the decoded-control bundle.
- Sub-module id_ex_decode: purely combinational instr → control bundle plus illegal flag. The top adds the registers, the stall/flush priority and the counter.

## Test plan
- Reset then add $3,$1,$2 (0x00221820) with in_valid → next cycle: ex_alu_op 2, ex_rd 3, ex_regwrite 1, ex_valid 1.
- lw $5,8($1) then sw $5,4($1) → first cycle: code 2, alusrc 1, memread 1, ex_imm 8, rd 5. Second cycle: code 4, memwrite 1, regwrite 0, ex_imm 4.
- beq, then stall held 3 cycles while instr changes → ex_alu_op stays 6 and ex_branch stays 1 for all 3 cycles. The next instr loads after stall drops.
- stall and flush together on a valid slt → bubble: ex_valid 0, ex_alu_op 4'hF.
- Opcode 0x3F streamed for 2^CNT_W+3 cycles → illegal high throughout; illegal_count saturates at 255 (CNT_W = 8).
- sll $4,$2,3 (0x000220C0) → with SLL_SHIFT_EN: code 8, ex_shamt 3. Without it: illegal pulse and bubble.
